conv_frame_sequencer: RTL and testbench
=======================================

// Module: conv_frame_sequencer
// PURPOSE
//   Sequences one convolution pass over an H x W feature map.
//   - Raster-scans the input pixel memory and drives the line-buffer shift.
//   - Flags complete KxK windows.
//   - Generates output-memory write strobes/addresses aligned to the MAC pipeline latency.
//   - Sits between top-level start control and the conv datapath (line buffer + MAC + result store).
// PARAMETERS
//   H          28   input map height (pixels)
//   W          28   input map width (pixels)
//   K          3    kernel size; requires 1 <= K <= H and K <= W
//   ADDR_W     10   input address width; requires 2**ADDR_W >= H*W
//   OADDR_W    10   output address width; requires 2**OADDR_W >= (H-K+1)*(W-K+1)
//   PIPE_LAT   4    MAC pipeline depth (enabled cycles from win_valid to result ready), >= 1
// PORTS
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous, active-low reset
//   start        in   1        begin frame; sampled only in IDLE
//   out_ready    in   1        downstream can accept; low = global stall
//   pipe_en      out  1        datapath clock-enable = busy & out_ready
//   in_rd_en     out  1        input memory read strobe
//   in_rd_addr   out  ADDR_W   input pixel address, raster order
//   shift_en     out  1        line buffer: shift in pixel returned by memory
//   win_valid    out  1        window at current shift is complete -> MAC input valid
//   out_wr_en    out  1        result store write strobe
//   out_wr_addr  out  OADDR_W  result address, raster order over (H-K+1)x(W-K+1)
//   busy         out  1        frame in progress
//   done         out  1        one-cycle pulse at frame completion
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; every output and internal counter = 0.
//   FSM states: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//   - IDLE: start=1 at edge E0 -> READ. From E0 on: busy=1, in_rd_addr=0, in_rd_en=out_ready.
//   - READ: each cycle with pipe_en=1:
//     - in_rd_en=1; in_rd_addr increments at the edge.
//     - When in_rd_addr = H*W-1 is issued -> DRAIN.
//   - DRAIN: no reads; shift/delay pipeline keeps advancing on pipe_en.
//     - Exit to DONE on the edge that writes the final out_wr_addr = (H-K+1)*(W-K+1)-1.
//   - DONE: exactly 1 cycle with done=1, busy=0 -> IDLE.
//   Memory read latency is 1 cycle:
//     - shift_en = in_rd_en registered (only on pipe_en).
//     - Shift-side row/col counters track the pixel being shifted.
//   win_valid = shift_en & (row >= K-1) & (col >= K-1), same cycle as shift_en.
//   out_wr_en = win_valid delayed PIPE_LAT enabled cycles.
//     - out_wr_addr increments after each write; wraps to 0 only on new frame start.
//   Stall (out_ready=0):
//     - in_rd_en, shift_en, win_valid and out_wr_en all forced to 0.
//     - All counters, addresses and delay-line contents hold.
//     - Resume is lossless; the write count per frame is always (H-K+1)*(W-K+1).
//   start while busy or in DONE: ignored, no effect.
//   start together with out_ready=0 in IDLE: frame starts; first read waits for out_ready.
//   rst mid-frame: immediate IDLE; in-flight valids discarded; no done pulse.
//     - Next start runs a clean frame from address 0.
// STRUCTURE
//   cnn_pkg:
//     - FSM state enum (IDLE/READ/DRAIN/DONE).
//     - Default H/W/K and derived constants NPIX=H*W, NOUT=(H-K+1)*(W-K+1).
//   Sub-module valid_delay_line: PIPE_LAT-stage 1-bit shift register.
//     - Clock-enable = pipe_en; async active-low clear.
//   Address/row/col counters and FSM stay in this module.
// TESTING
//   1 Reset asserted mid-run, then held -> all outputs 0, state IDLE; release -> outputs stay 0 until start.
//   2 Defaults, out_ready=1, start at E0 -> expected timing (c0 = cycle after E0):
//       - 784 consecutive reads, addr 0..783 at c0..c0+783.
//       - First win_valid at c0+59.
//       - First out_wr_en at c0+63, addr 0; last out_wr_en at c0+788, addr 675.
//       - done=1 at c0+789 only; 676 writes total.
//   3 Defaults, out_ready=0 for 10 cycles starting c0+100 -> no strobes during stall,
//       addresses frozen, 676 writes, addr 0..675 gapless, done at c0+799.
//   4 start pulsed at c0+300 and again during DONE -> ignored; exactly one done, 676 writes.
//   5 rst low at c0+400 for 2 cycles, then start -> no done from aborted frame;
//       new frame repeats scenario 2 timing from address 0.
//   6 H=W=K=3, PIPE_LAT=1 -> 9 reads, single out_wr_en addr 0 at c0+10, done at c0+11.

Source files
------------

// File: rtl/conv_frame_sequencer_pkg.sv
// conv_frame_sequencer_pkg: shared FSM state type and default map/kernel geometry
package conv_frame_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;
  localparam int H_DEF = 28;
  localparam int W_DEF = 28;
  localparam int K_DEF = 3;
  localparam int NPIX_DEF = H_DEF * W_DEF;
  localparam int NOUT_DEF = (H_DEF - K_DEF + 1) * (W_DEF - K_DEF + 1);
  function automatic int n_out(input int h, input int w, input int k);
    return (h - k + 1) * (w - k + 1);
  endfunction
endpackage

// File: rtl/conv_frame_sequencer_if.sv
// conv_frame_sequencer_if: start/stall control plus memory, line-buffer and result-store strobes
interface conv_frame_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 10
);
  logic               start;
  logic               out_ready;
  logic               pipe_en;
  logic               in_rd_en;
  logic [ADDR_W-1:0]  in_rd_addr;
  logic               shift_en;
  logic               win_valid;
  logic               out_wr_en;
  logic [OADDR_W-1:0] out_wr_addr;
  logic               busy;
  logic               done;
  modport master (
    input  start, out_ready,
    output pipe_en, in_rd_en, in_rd_addr, shift_en, win_valid,
           out_wr_en, out_wr_addr, busy, done
  );
  modport slave (
    output start, out_ready,
    input  pipe_en, in_rd_en, in_rd_addr, shift_en, win_valid,
           out_wr_en, out_wr_addr, busy, done
  );
endinterface

// File: rtl/conv_frame_sequencer_valid_delay_line.sv
// valid_delay_line: N-stage 1-bit shift register advancing only when enabled
module valid_delay_line #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] q_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else if (en_i) begin
      q_q[0] <= d_i;
      for (int i = 1; i < N; i++) q_q[i] <= q_q[i-1];
    end
  end
  assign q_o = q_q[N-1];
endmodule

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: raster-scans an HxW map, flags KxK windows and times result writes
module conv_frame_sequencer
  import conv_frame_sequencer_pkg::*;
#(
  parameter int H        = H_DEF,
  parameter int W        = W_DEF,
  parameter int K        = K_DEF,
  parameter int ADDR_W   = 10,
  parameter int OADDR_W  = 10,
  parameter int PIPE_LAT = 4
) (
  input logic clk,
  input logic rst_n,
  conv_frame_sequencer_if.master bus
);
  localparam int NPIX = H * W;
  localparam int NOUT = n_out(H, W, K);
  localparam int RW = $clog2(H + 1);
  localparam int CW = $clog2(W + 1);
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [OADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic               sh_q, sh_d;
  logic               busy, pipe_en, frame_start, rd, sh, win, wr, dl_q;
  assign busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign pipe_en     = busy && bus.out_ready;
  assign frame_start = (state_q == ST_IDLE) && bus.start;
  assign rd          = (state_q == ST_READ) && pipe_en;
  assign sh          = sh_q && pipe_en;
  // row/col describe the pixel being shifted this cycle, one cycle behind the read
  assign win         = sh && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign wr          = dl_q && pipe_en;
  always_comb begin
    state_d   = frame_start ? ST_READ :
                (rd && rd_addr_q == ADDR_W'(NPIX - 1)) ? ST_DRAIN :
                (state_q == ST_DRAIN && wr && wr_addr_q == OADDR_W'(NOUT - 1)) ? ST_DONE :
                (state_q == ST_DONE) ? ST_IDLE : state_q;
    rd_addr_d = frame_start ? '0 : rd ? rd_addr_q + 1'b1 : rd_addr_q;
    wr_addr_d = frame_start ? '0 : wr ? wr_addr_q + 1'b1 : wr_addr_q;
    sh_d      = frame_start ? 1'b0 : pipe_en ? rd : sh_q;
    col_d     = frame_start ? '0 : !sh ? col_q : (col_q == CW'(W - 1)) ? '0 : col_q + 1'b1;
    row_d     = frame_start ? '0 : (sh && col_q == CW'(W - 1)) ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      sh_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      sh_q      <= sh_d;
    end
  end
  valid_delay_line #(.N(PIPE_LAT)) u_dl (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (pipe_en),
    .d_i  (win),
    .q_o  (dl_q)
  );
  assign bus.pipe_en     = pipe_en;
  assign bus.in_rd_en    = rd;
  assign bus.in_rd_addr  = rd_addr_q;
  assign bus.shift_en    = sh;
  assign bus.win_valid   = win;
  assign bus.out_wr_en   = wr;
  assign bus.out_wr_addr = wr_addr_q;
  assign bus.busy        = busy;
  assign bus.done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: scoreboard bench for a 28x28/K3 and a 3x3/K3 sequencer
module tb_conv_frame_sequencer;
  import conv_frame_sequencer_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_a[8][$];
  int   exp_c[8][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv_frame_sequencer_if #(.ADDR_W(10), .OADDR_W(10)) b0 ();
  conv_frame_sequencer_if #(.ADDR_W(4), .OADDR_W(2)) b1 ();
  conv_frame_sequencer #(.H(28), .W(28), .K(3), .ADDR_W(10), .OADDR_W(10), .PIPE_LAT(4))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  conv_frame_sequencer #(.H(3), .W(3), .K(3), .ADDR_W(4), .OADDR_W(2), .PIPE_LAT(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  // queue index = dut*4 + {0:read,1:window,2:write,3:done}
  task automatic chk(input int i, input string nm, input int addr);
    int ea, ec;
    n_cmp++;
    if (exp_c[i].size() == 0) begin
      n_bad++;
      $display("FAIL %s unexpected strobe at cyc %0d addr %0d, none required", nm, cyc, addr);
    end else begin
      ea = exp_a[i].pop_front();
      ec = exp_c[i].pop_front();
      if (ea != addr || ec != cyc) begin
        n_bad++;
        $display("FAIL %s got addr %0d at cyc %0d, required addr %0d at cyc %0d", nm, addr, cyc, ea, ec);
      end
    end
  endtask
  always @(negedge clk) begin
    if (b0.in_rd_en)  chk(0, "rd0", int'(b0.in_rd_addr));
    if (b0.win_valid) chk(1, "win0", 0);
    if (b0.out_wr_en) chk(2, "wr0", int'(b0.out_wr_addr));
    if (b0.done)      chk(3, "done0", 0);
    if (b1.in_rd_en)  chk(4, "rd1", int'(b1.in_rd_addr));
    if (b1.win_valid) chk(5, "win1", 0);
    if (b1.out_wr_en) chk(6, "wr1", int'(b1.out_wr_addr));
    if (b1.done)      chk(7, "done1", 0);
  end
  function automatic int ecyc(input int c0, input int k, input int ss, input int sl);
    int c;
    c = c0 + k;
    return (sl > 0 && c >= ss) ? c + sl : c;
  endfunction
  task automatic push_frame(input int d, input int c0, input int ss, input int sl);
    int h, w, k, lat, o, lastw;
    h = d ? 3 : H_DEF;
    w = d ? 3 : W_DEF;
    k = d ? 3 : K_DEF;
    lat = d ? 1 : 4;
    o = 0;
    lastw = 0;
    for (int i = 0; i < h * w; i++) begin
      exp_a[d*4].push_back(i);
      exp_c[d*4].push_back(ecyc(c0, i, ss, sl));
    end
    for (int p = 0; p < h * w; p++)
      if (p / w >= k - 1 && p % w >= k - 1) begin
        exp_a[d*4+1].push_back(0);
        exp_c[d*4+1].push_back(ecyc(c0, p + 1, ss, sl));
        lastw = ecyc(c0, p + 1 + lat, ss, sl);
        exp_a[d*4+2].push_back(o);
        exp_c[d*4+2].push_back(lastw);
        o++;
      end
    exp_a[d*4+3].push_back(0);
    exp_c[d*4+3].push_back(lastw + 1);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic to_cyc(input int n);
    while (cyc < n) step();
  endtask
  task automatic start_frame(input int d, input int ssrel, input int sl, output int c0);
    c0 = cyc + 1;
    if (d == 0) b0.start = 1'b1;
    else b1.start = 1'b1;
    push_frame(d, c0, c0 + ssrel, sl);
    step();
    b0.start = 1'b0;
    b1.start = 1'b0;
  endtask
  task automatic flush();
    for (int i = 0; i < 8; i++) begin
      exp_a[i].delete();
      exp_c[i].delete();
    end
  endtask
  task automatic wait_idle();
    int pend;
    for (int t = 0; t < 2000; t++) begin
      pend = 0;
      for (int i = 0; i < 8; i++) pend += exp_c[i].size();
      if (pend == 0) break;
      step();
    end
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (exp_c[i].size() != 0) begin
        n_bad++;
        $display("FAIL missing q%0d: %0d strobes still outstanding, required 0", i, exp_c[i].size());
        exp_a[i].delete();
        exp_c[i].delete();
      end
    end
  endtask
  task automatic chk_quiet(input string nm);
    logic [29:0] v0;
    logic [14:0] v1;
    v0 = {b0.pipe_en, b0.in_rd_en, b0.in_rd_addr, b0.shift_en, b0.win_valid,
          b0.out_wr_en, b0.out_wr_addr, b0.busy, b0.done};
    v1 = {b1.pipe_en, b1.in_rd_en, b1.in_rd_addr, b1.shift_en, b1.win_valid,
          b1.out_wr_en, b1.out_wr_addr, b1.busy, b1.done};
    n_cmp++;
    if (v0 != '0 || v1 != '0) begin
      n_bad++;
      $display("FAIL %s outputs got %h/%h, required 0/0", nm, v0, v1);
    end
  endtask
  initial begin
    int c0;
    b0.start = 0; b0.out_ready = 1;
    b1.start = 0; b1.out_ready = 1;
    repeat (3) step();
    chk_quiet("por");
    rst_n = 1;
    repeat (2) step();
    start_frame(0, 0, 0, c0);
    wait_idle();
    start_frame(0, 100, 10, c0);
    to_cyc(c0 + 100);
    b0.out_ready = 0;
    repeat (5) step();
    n_cmp++;
    if (b0.in_rd_addr != 10'd100 || b0.pipe_en !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_hold got addr %0d pipe_en %b, required 100/0", b0.in_rd_addr, b0.pipe_en);
    end
    to_cyc(c0 + 110);
    b0.out_ready = 1;
    wait_idle();
    start_frame(0, 0, 0, c0);
    to_cyc(c0 + 300);
    b0.start = 1;
    step();
    b0.start = 0;
    to_cyc(c0 + 789);
    b0.start = 1;
    step();
    b0.start = 0;
    wait_idle();
    start_frame(0, 0, 0, c0);
    to_cyc(c0 + 400);
    rst_n = 0;
    flush();
    step();
    chk_quiet("rst_held");
    step();
    rst_n = 1;
    repeat (4) step();
    chk_quiet("rst_release");
    start_frame(0, 0, 0, c0);
    wait_idle();
    start_frame(1, 0, 0, c0);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
